// File: rtl/tt_rr_arb_mux_pkg.sv
// Shared helpers for the round-robin arbiter mux: circular one-hot pick and one-hot decode.
package tt_rr_arb_mux_pkg;

    localparam int RR_MAX_W = 64;
    localparam int RR_IDX_W = 6;

    typedef logic [RR_MAX_W-1:0] rr_vec_t;

    function automatic int onehot_to_idx(rr_vec_t v);
        int idx;
        idx = 0;
        for (int i = 0; i < RR_MAX_W; i++) begin
            if (v[i]) idx = idx | i;
        end
        return idx;
    endfunction

    // First set bit of req among the low n bits, searching upward from the bit after ptr.
    function automatic rr_vec_t rr_pick(rr_vec_t req, rr_vec_t ptr, int n);
        rr_vec_t g;
        int      start;
        int      idx;
        logic    found;
        g     = '0;
        found = 1'b0;
        start = onehot_to_idx(ptr) + 1;
        if (start >= n) start = 0;
        for (int k = 0; k < RR_MAX_W; k++) begin
            idx = start + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && req[idx[RR_IDX_W-1:0]]) begin
                g[idx[RR_IDX_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/tt_rr_arb_mux_arbiter.sv
// Round-robin grant generator with a last-grant pointer; packet lock when TT_RR_ARB_MUX_LOCK_EN is defined.
module tt_rr_arbiter
    import tt_rr_arb_mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         xfer,
    input  logic [N-1:0] last,
    output logic [N-1:0] grant
);

    logic [N-1:0] ptr;
    rr_vec_t      pick;
    logic         unused_pick_hi;

    always_comb pick = rr_pick(RR_MAX_W'(req), RR_MAX_W'(ptr), N);
    assign unused_pick_hi = ^pick[RR_MAX_W-1:N];

`ifdef TT_RR_ARB_MUX_LOCK_EN
    logic         lock;
    logic [N-1:0] lock_sel;
    logic         grant_last;

    // While locked, the owner alone may be granted; a hole simply yields no grant.
    assign grant      = lock ? (lock_sel & req) : pick[N-1:0];
    assign grant_last = |(grant & last);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= {1'b1, {(N-1){1'b0}}};
            lock     <= 1'b0;
            lock_sel <= '0;
        end else if (xfer) begin
            if (grant_last) begin
                ptr  <= grant;
                lock <= 1'b0;
            end else begin
                lock     <= 1'b1;
                lock_sel <= grant;
            end
        end
    end
`else
    logic unused_last;

    assign grant       = pick[N-1:0];
    assign unused_last = ^last;

    always_ff @(posedge clk) begin
        if (reset)     ptr <= {1'b1, {(N-1){1'b0}}};
        else if (xfer) ptr <= grant;
    end
`endif

endmodule

// File: rtl/tt_rr_arb_mux.sv
// Valid/ready round-robin arbiter fused with a one-hot AND-OR mux and output register.
// Optional packet locking via TT_RR_ARB_MUX_LOCK_EN.
module tt_rr_arb_mux
    import tt_rr_arb_mux_pkg::*;
#(
    parameter int VALUE_WIDTH        = 32,
    parameter int MUX_WIDTH          = 4,
    parameter bit DISABLE_ASSERTIONS = 1'b0
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic [MUX_WIDTH-1:0]                  i_valid,
    input  logic [MUX_WIDTH-1:0][VALUE_WIDTH-1:0] i_inputs,
    input  logic [MUX_WIDTH-1:0]                  i_last,
    output logic [MUX_WIDTH-1:0]                  o_ready,
    output logic                                  o_valid,
    output logic [VALUE_WIDTH-1:0]                o_output,
    output logic [MUX_WIDTH-1:0]                  o_select,
    input  logic                                  i_ready
);

    logic [MUX_WIDTH-1:0]                  grant;
    logic                                  can_load;
    logic                                  xfer;
    logic [MUX_WIDTH-1:0][VALUE_WIDTH-1:0] masked;
    logic [VALUE_WIDTH-1:0]                mux_data;

    tt_rr_arbiter #(.N(MUX_WIDTH)) u_arb (
        .clk   (i_clk),
        .reset (i_reset),
        .req   (i_valid),
        .xfer  (xfer),
        .last  (i_last),
        .grant (grant)
    );

    // Reset gates ready so nothing is accepted while the register is being cleared.
    assign can_load = !o_valid || i_ready;
    assign o_ready  = grant & {MUX_WIDTH{can_load && !i_reset}};
    assign xfer     = |(i_valid & o_ready);

    for (genvar g = 0; g < MUX_WIDTH; g++) begin : g_lane
        assign masked[g] = i_inputs[g] & {VALUE_WIDTH{grant[g]}};
    end

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < MUX_WIDTH; i++) mux_data = mux_data | masked[i];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid  <= 1'b0;
            o_output <= '0;
            o_select <= '0;
        end else if (xfer) begin
            o_valid  <= 1'b1;
            o_output <= mux_data;
            o_select <= grant;
        end else if (i_ready) begin
            o_valid  <= 1'b0;
            o_select <= '0;
        end
    end

    if (!DISABLE_ASSERTIONS) begin : g_chk
        a_grant_onehot : assert property (@(posedge i_clk) disable iff (i_reset)
            $onehot0(grant));
        a_stall_stable : assert property (@(posedge i_clk) disable iff (i_reset)
            (o_valid && !i_ready) |=> ($stable(o_output) && $stable(o_select)));
    end

endmodule

// File: tb/tb_tt_rr_arb_mux.sv
// Directed bench for tt_rr_arb_mux: reset, fairness, skip, backpressure, mid-stall reset, lock/interleave.
module tb_tt_rr_arb_mux;

    localparam int VW = 32;
    localparam int MW = 4;

    logic                   i_clk;
    logic                   i_reset;
    logic [MW-1:0]          i_valid;
    logic [MW-1:0][VW-1:0]  i_inputs;
    logic [MW-1:0]          i_last;
    logic [MW-1:0]          o_ready;
    logic                   o_valid;
    logic [VW-1:0]          o_output;
    logic [MW-1:0]          o_select;
    logic                   i_ready;

    int checks = 0;
    int errors = 0;

    tt_rr_arb_mux #(.VALUE_WIDTH(VW), .MUX_WIDTH(MW), .DISABLE_ASSERTIONS(1'b0)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_valid  (i_valid),
        .i_inputs (i_inputs),
        .i_last   (i_last),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o_output (o_output),
        .o_select (o_select),
        .i_ready  (i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    int skip_idx[5]  = '{3, 1, 3, 1, 3};
    int raise_idx[3] = '{0, 1, 3};
`ifdef TT_RR_ARB_MUX_LOCK_EN
    int lk_idx[4]    = '{2, 2, 2, 0};
`else
    int lk_idx[4]    = '{2, 0, 2, 0};
`endif
    int r2beats;

    initial begin
        i_clk   = 1'b0;
        i_reset = 1'b1;
        i_valid = '1;
        i_ready = 1'b1;
        i_last  = '0;
        for (int m = 0; m < MW; m++) i_inputs[m] = 32'hA0 + m;

        repeat (2) begin
            tick();
            chk("rst_valid",  o_valid,  0);
            chk("rst_output", o_output, 0);
            chk("rst_select", o_select, 0);
            chk("rst_ready",  o_ready,  0);
        end

        i_reset = 1'b0;
        #1;
        chk("first_ready", o_ready, 32'h1);

        for (int b = 0; b < 6; b++) begin
            tick();
            chk("fair_out",   o_output, 32'hA0 + (b % 4));
            chk("fair_sel",   o_select, 32'(1 << (b % 4)));
            chk("fair_valid", o_valid,  1);
        end

        i_valid = 4'b1010;
        for (int b = 0; b < 5; b++) begin
            tick();
            chk("skip_sel", o_select, 32'(1 << skip_idx[b]));
            chk("skip_out", o_output, 32'hA0 + skip_idx[b]);
        end
        i_valid = 4'b1011;
        for (int b = 0; b < 3; b++) begin
            tick();
            chk("raise_sel", o_select, 32'(1 << raise_idx[b]));
        end

        i_valid = '0;
        tick();
        chk("drain_valid", o_valid,  0);
        chk("drain_sel",   o_select, 0);
        chk("drain_hold",  o_output, 32'hA3);

        i_valid = '1;
        i_ready = 1'b0;
        #1;
        chk("bp_empty_ready", o_ready, 32'h1);
        tick();
        chk("bp_load_out", o_output, 32'hA0);
        chk("bp_load_sel", o_select, 32'h1);
        repeat (5) begin
            tick();
            chk("bp_ready", o_ready,  0);
            chk("bp_out",   o_output, 32'hA0);
            chk("bp_sel",   o_select, 32'h1);
            chk("bp_valid", o_valid,  1);
        end
        i_ready = 1'b1;
        #1;
        chk("bp_rel_ready", o_ready, 32'h2);
        tick();
        chk("bp_rel_out", o_output, 32'hA1);
        chk("bp_rel_sel", o_select, 32'h2);

        i_ready = 1'b0;
        i_reset = 1'b1;
        tick();
        chk("mrst_valid",  o_valid,  0);
        chk("mrst_output", o_output, 0);
        chk("mrst_select", o_select, 0);
        i_reset = 1'b0;
        i_ready = 1'b1;
        #1;
        chk("mrst_ready", o_ready, 32'h1);
        tick();
        chk("mrst_out", o_output, 32'hA0);

        i_valid = 4'b0101;
        i_last  = 4'b0001;
        r2beats = 0;
        for (int c = 0; c < 4; c++) begin
            i_last[2] = (r2beats == 2);
            tick();
            chk("lock_sel", o_select, 32'(1 << lk_idx[c]));
            if (lk_idx[c] == 2) r2beats++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
